// File: rtl/pattern_count_sched_if.sv
// Request/response bundle for pattern_count_sched: NUM_REQ packed request
// channels toward the matcher and one result channel back.
interface pattern_count_sched_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int PATTERN_WIDTH = 3,
    parameter int NUM_REQ       = 4,
    parameter int COUNT_WIDTH   = $clog2(DATA_WIDTH) + 1
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Both channels use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; the payload is held stable by its source
    // while valid is high and ready is low.
    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ-1:0]               req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0]    req_data;
    logic [NUM_REQ*PATTERN_WIDTH-1:0] req_pattern;
    logic                             rsp_valid;
    logic                             rsp_ready;
    logic [COUNT_WIDTH-1:0]           rsp_count;
    logic [ID_W-1:0]                  rsp_id;
    logic                             busy;

    modport master (
        output req_valid, req_data, req_pattern, rsp_ready,
        input  req_ready, rsp_valid, rsp_count, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_data, req_pattern, rsp_ready,
        output req_ready, rsp_valid, rsp_count, rsp_id, busy
    );
endinterface

// File: rtl/pattern_count_sched.sv
// Shared sliding-window pattern counter: a round-robin arbiter picks one
// requester, then one overlapping window is compared per cycle, MSB first.
module pattern_count_sched #(
    parameter int DATA_WIDTH    = 32,
    parameter int PATTERN_WIDTH = 3,
    parameter int NUM_REQ       = 4,
    parameter int COUNT_WIDTH   = $clog2(DATA_WIDTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    pattern_count_sched_if.slave bus,
    output logic [1:0]          dbg_state
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0]    data_q;
    logic [PATTERN_WIDTH-1:0] pattern_q;
    logic [ID_W-1:0]          id_q;
    logic [ID_W-1:0]          last_grant;
    logic [ID_W-1:0]          grant_id;
    logic [ID_W-1:0]          cand;
    logic [COUNT_WIDTH-1:0]   count_q;
    logic [IDX_W-1:0]         idx_q;
    logic [PATTERN_WIDTH-1:0] window;
    logic                     grant_any;
    logic                     last_window;
    logic                     window_match;

    // Search starts just after the last winner; reset leaves last_grant at
    // NUM_REQ-1 so requester 0 has first priority.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = '0;
        if (state == IDLE && !rst) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
                if (!grant_any && bus.req_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_id  = cand;
                end
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (grant_any) begin
            bus.req_ready[grant_id] = 1'b1;
        end
    end

    // Window at idx covers bits idx down to idx-PATTERN_WIDTH+1.
    assign window       = PATTERN_WIDTH'(data_q >> (int'(idx_q) - (PATTERN_WIDTH - 1)));
    assign window_match = (window == pattern_q);
    assign last_window  = (idx_q == IDX_W'(PATTERN_WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant_any)     state_nxt = SCAN;
            SCAN: if (last_window)   state_nxt = RESP;
            RESP: if (bus.rsp_ready) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q     <= '0;
            pattern_q  <= '0;
            id_q       <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            count_q    <= '0;
            idx_q      <= IDX_W'(DATA_WIDTH - 1);
        end else if (grant_any) begin
            data_q     <= bus.req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
            pattern_q  <= bus.req_pattern[int'(grant_id)*PATTERN_WIDTH +: PATTERN_WIDTH];
            id_q       <= grant_id;
            last_grant <= grant_id;
            count_q    <= '0;
            idx_q      <= IDX_W'(DATA_WIDTH - 1);
        end else if (state == SCAN) begin
            if (window_match) begin
                count_q <= count_q + COUNT_WIDTH'(1);
            end
            idx_q <= idx_q - IDX_W'(1);
        end
    end

    // Result fields read zero outside RESP so a stale count never leaks.
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_count = (state == RESP) ? count_q : '0;
    assign bus.rsp_id    = (state == RESP) ? id_q : '0;
    assign bus.busy      = (state != IDLE);
    assign dbg_state     = state;
endmodule

// File: tb/tb_pattern_count_sched.sv
// Directed bench for pattern_count_sched: default 32/3/4 instance plus a
// full-width 8/8/2 instance for the single-window case.
module tb_pattern_count_sched;
    localparam int DW = 32;
    localparam int PW = 3;
    localparam int NR = 4;
    localparam int CW = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;
    logic [1:0] dbg_state_f;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    pattern_count_sched_if #(.DATA_WIDTH(DW), .PATTERN_WIDTH(PW), .NUM_REQ(NR), .COUNT_WIDTH(CW)) bus ();
    pattern_count_sched_if #(.DATA_WIDTH(8), .PATTERN_WIDTH(8), .NUM_REQ(2), .COUNT_WIDTH(4)) bus_f ();

    pattern_count_sched #(.DATA_WIDTH(DW), .PATTERN_WIDTH(PW), .NUM_REQ(NR), .COUNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    pattern_count_sched #(.DATA_WIDTH(8), .PATTERN_WIDTH(8), .NUM_REQ(2), .COUNT_WIDTH(4)) dut_f (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_f),
        .dbg_state (dbg_state_f)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_rsp_f(output int n);
        n = 0;
        while (bus_f.rsp_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] d, input logic [PW-1:0] p);
        bus.req_data[i*DW +: DW]    = d;
        bus.req_pattern[i*PW +: PW] = p;
    endtask

    // Single job from IDLE with only requester i valid and rsp_ready already high.
    task automatic do_job(input string tag, input int i, input logic [DW-1:0] d,
                          input logic [PW-1:0] p, input int exp_cnt);
        int n;
        set_req(i, d, p);
        bus.req_valid = NR'(1) << i;
        #1;
        check({tag, "_ready"}, bus.req_ready, 64'(1) << i);
        tick();
        bus.req_valid = '0;
        check({tag, "_busy"}, bus.busy, 1'b1);
        wait_rsp(n);
        check({tag, "_latency"}, n, 30);
        check({tag, "_count"}, bus.rsp_count, exp_cnt);
        check({tag, "_id"}, bus.rsp_id, i);
        tick();
        check({tag, "_one_cycle"}, bus.rsp_valid, 1'b0);
        check({tag, "_idle"}, bus.busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int hs_cyc;
        int prev_hs;
        int exp_cnt[4];
        exp_cnt = '{30, 15, 0, 2};

        bus.req_valid   = '0;
        bus.req_data    = '0;
        bus.req_pattern = '0;
        bus.rsp_ready   = 1'b0;
        bus_f.req_valid   = '0;
        bus_f.req_data    = '0;
        bus_f.req_pattern = '0;
        bus_f.rsp_ready   = 1'b0;

        // Reset: outputs idle, no grant even with every request valid.
        tick();
        bus.req_valid = '1;
        #1;
        check("rst_ready", bus.req_ready, 4'b0000);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_count", bus.rsp_count, 0);
        check("rst_id", bus.rsp_id, 0);
        check("rst_state", dbg_state, 2'd0);
        tick();
        rst = 1'b0;
        bus.req_valid = '0;

        // Req0 all ones, pattern 111, response held for 10 cycles.
        set_req(0, 32'hFFFF_FFFF, 3'b111);
        bus.req_valid = 4'b0001;
        #1;
        check("r0_ready", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = '0;
        check("r0_busy", bus.busy, 1'b1);
        check("r0_state_scan", dbg_state, 2'd1);
        check("r0_scan_ready", bus.req_ready, 4'b0000);
        check("r0_scan_rsp_valid", bus.rsp_valid, 1'b0);
        wait_rsp(n);
        check("r0_latency", n, 30);
        check("r0_count", bus.rsp_count, 30);
        check("r0_id", bus.rsp_id, 0);
        check("r0_state_resp", dbg_state, 2'd2);
        bus.req_valid = 4'b0010;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("hold_valid", bus.rsp_valid, 1'b1);
            check("hold_count", bus.rsp_count, 30);
            check("hold_id", bus.rsp_id, 0);
            check("hold_ready", bus.req_ready, 4'b0000);
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        tick();
        check("release_valid", bus.rsp_valid, 1'b0);
        check("release_state", dbg_state, 2'd0);
        check("release_count", bus.rsp_count, 0);

        // Req2 jobs with rsp_ready already high on entry to RESP.
        do_job("r2_alt", 2, 32'hAAAA_AAAA, 3'b101, 15);
        do_job("r2_zero", 2, 32'h0000_0000, 3'b111, 0);

        // Round-robin from reset: grants 0,1,2,3,0, one every 32 cycles.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rr_rst_state", dbg_state, 2'd0);
        set_req(0, 32'hFFFF_FFFF, 3'b111);
        set_req(1, 32'hAAAA_AAAA, 3'b101);
        set_req(2, 32'h0000_0000, 3'b111);
        set_req(3, 32'h0000_000F, 3'b111);
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        prev_hs = 0;
        for (int j = 0; j < 5; j++) begin
            #1;
            check("rr_grant", bus.req_ready, 64'(1) << (j % 4));
            tick();
            hs_cyc = cyc;
            if (j > 0) check("rr_spacing", hs_cyc - prev_hs, 32);
            prev_hs = hs_cyc;
            wait_rsp(n);
            check("rr_latency", n, 30);
            check("rr_id", bus.rsp_id, j % 4);
            check("rr_count", bus.rsp_count, exp_cnt[j % 4]);
            tick();
        end
        bus.req_valid = '0;

        // Reset mid-scan at window 12, then rerun the same job.
        bus.req_valid = 4'b0001;
        #1;
        check("abort_ready", bus.req_ready, 4'b0001);
        tick();
        repeat (12) tick();
        check("abort_scanning", dbg_state, 2'd1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_state", dbg_state, 2'd0);
        check("abort_rsp_valid", bus.rsp_valid, 1'b0);
        check("abort_count", bus.rsp_count, 0);
        check("abort_id", bus.rsp_id, 0);
        check("abort_req_ready", bus.req_ready, 4'b0000);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rerun_ready", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = '0;
        wait_rsp(n);
        check("rerun_latency", n, 30);
        check("rerun_count", bus.rsp_count, 30);
        check("rerun_id", bus.rsp_id, 0);
        tick();
        check("rerun_idle", bus.busy, 1'b0);

        // Req1 scribbles its inputs every cycle after the handshake.
        set_req(1, 32'hF0F0_F0F0, 3'b111);
        bus.req_valid = 4'b0010;
        #1;
        check("scribble_ready", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid = '0;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 100) begin
            bus.req_data    = {$urandom, $urandom, $urandom, $urandom};
            bus.req_pattern = (NR*PW)'($urandom);
            tick();
            n++;
        end
        check("scribble_latency", n, 30);
        check("scribble_count", bus.rsp_count, 8);
        check("scribble_id", bus.rsp_id, 1);
        tick();

        // Full-width pattern: single window, count 0 or 1.
        bus_f.rsp_ready   = 1'b1;
        bus_f.req_data    = {8'hA5, 8'hA5};
        bus_f.req_pattern = {8'hA5, 8'h5A};
        bus_f.req_valid   = 2'b10;
        #1;
        check("full_ready1", bus_f.req_ready, 2'b10);
        tick();
        bus_f.req_valid = '0;
        wait_rsp_f(n);
        check("full_latency1", n, 1);
        check("full_count1", bus_f.rsp_count, 1);
        check("full_id1", bus_f.rsp_id, 1);
        tick();
        bus_f.req_valid = 2'b01;
        #1;
        check("full_ready0", bus_f.req_ready, 2'b01);
        tick();
        bus_f.req_valid = '0;
        wait_rsp_f(n);
        check("full_latency0", n, 1);
        check("full_count0", bus_f.rsp_count, 0);
        check("full_id0", bus_f.rsp_id, 0);
        tick();
        check("full_idle", bus_f.busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
